// File: rtl/regfile8_sb.sv
// Eight-entry register file with two registered read ports and a per-register pending-write scoreboard.
// Define REGFILE_BYPASS_EN to forward same-edge writeback data to the read ports and to suppress the matching hazard.
module regfile8_sb #(
  parameter int k = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         write,
  input  logic [2:0]   writenum,
  input  logic [k-1:0] data_in,
  input  logic [2:0]   readnum_a,
  input  logic [2:0]   readnum_b,
  input  logic         stall,
  input  logic         issue,
  input  logic [2:0]   issue_dst,
  output logic [k-1:0] data_a,
  output logic [k-1:0] data_b,
  output logic         hazard_a,
  output logic         hazard_b,
  output logic [7:0]   busy,
  output logic         sb_err
);

  logic [k-1:0] regs_q [8];
  logic [k-1:0] regs_d [8];
  logic [1:0]   cnt_q  [8];
  logic [1:0]   cnt_d  [8];
  logic [k-1:0] data_a_q, data_a_d;
  logic [k-1:0] data_b_q, data_b_d;
  logic         sb_err_q, sb_err_d;
  logic [7:0]   iss_hit, wr_hit;
  logic [k-1:0] sel_a, sel_b;

  for (genvar gi = 0; gi < 8; gi++) begin : g_dec
    assign iss_hit[gi] = issue && (issue_dst == 3'(gi));
    assign wr_hit[gi]  = write && (writenum == 3'(gi));
    assign busy[gi]    = (cnt_q[gi] != 2'd0);
  end

  // Storage and scoreboard next state; an issue and a write on the same register cancel out.
  always_comb begin
    sb_err_d = sb_err_q;
    for (int i = 0; i < 8; i++) begin
      regs_d[i] = wr_hit[i] ? data_in : regs_q[i];
      cnt_d[i]  = cnt_q[i];
      if (iss_hit[i] && !wr_hit[i]) begin
        if (cnt_q[i] == 2'd3) sb_err_d = 1'b1;
        else                  cnt_d[i] = cnt_q[i] + 2'd1;
      end else if (wr_hit[i] && !iss_hit[i]) begin
        if (cnt_q[i] == 2'd0) sb_err_d = 1'b1;
        else                  cnt_d[i] = cnt_q[i] - 2'd1;
      end
    end
  end

  always_comb begin
    sel_a    = regs_q[readnum_a];
    sel_b    = regs_q[readnum_b];
    hazard_a = (cnt_q[readnum_a] != 2'd0);
    hazard_b = (cnt_q[readnum_b] != 2'd0);
`ifdef REGFILE_BYPASS_EN
    if (write && (writenum == readnum_a)) sel_a = data_in;
    if (write && (writenum == readnum_b)) sel_b = data_in;
    // The last outstanding write is landing now and nothing new re-claims the register.
    if (wr_hit[readnum_a] && (cnt_q[readnum_a] == 2'd1) && !iss_hit[readnum_a]) hazard_a = 1'b0;
    if (wr_hit[readnum_b] && (cnt_q[readnum_b] == 2'd1) && !iss_hit[readnum_b]) hazard_b = 1'b0;
`endif
    data_a_d = stall ? data_a_q : sel_a;
    data_b_d = stall ? data_b_q : sel_b;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= '0;
        cnt_q[i]  <= 2'd0;
      end
      data_a_q <= '0;
      data_b_q <= '0;
      sb_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= regs_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
      data_a_q <= data_a_d;
      data_b_q <= data_b_d;
      sb_err_q <= sb_err_d;
    end
  end

  assign data_a = data_a_q;
  assign data_b = data_b_q;
  assign sb_err = sb_err_q;

endmodule
